// File: rtl/mult_copro_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_copro_if
//  Purpose  : Co-processor port bundle (start/ready handshake, push/pop stack
//             access, sticky error) between the processor and mult_copro.
//  Revision : 1.0  initial release
// ============================================================================
interface mult_copro_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    logic             dpsh;
    logic [WIDTH-1:0] dinp;
    logic             dpop;
    logic [WIDTH-1:0] dout;
    logic             err;

    modport master (
        output start, dpsh, dinp, dpop,
        input  ready, dout, err
    );

    modport slave (
        input  start, dpsh, dinp, dpop,
        output ready, dout, err
    );
endinterface
`default_nettype wire

// File: rtl/mult_copro.sv
`default_nettype none
// ============================================================================
//  Module   : mult_copro
//  Purpose  : LIFO-fed unsigned shift-add multiplier; product pushed back
//             as two words with the low word on top.
//  Revision : 1.0  initial release
// ============================================================================
module mult_copro #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  wire logic   ck,
    input  wire logic   rb,
    mult_copro_if.slave cp
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   stk_q [DEPTH];
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               err_q, err_d;

    logic               we0, we1;
    logic [IW-1:0]      wi0, wi1;
    logic [WIDTH-1:0]   wd0, wd1;

    logic [IW-1:0]      top_idx, sec_idx, push_idx, push2_idx;
    logic [WIDTH:0]     mul_sum;

    assign top_idx   = IW'(cnt_q - CW'(1));
    assign sec_idx   = IW'(cnt_q - CW'(2));
    assign push_idx  = IW'(cnt_q);
    assign push2_idx = IW'(cnt_q + CW'(1));

    // Carry out of the upper-half add lands in the MSB after the shift.
    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (a_q[0] ? b_q : '0)};

    assign cp.dout  = (cnt_q == '0) ? '0 : stk_q[top_idx];
    assign cp.ready = ((state_q == S_IDLE) && !cp.start) || (state_q == S_DONE);
    assign cp.err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        bit_d   = bit_q;
        err_d   = err_q;
        we0     = 1'b0;
        wi0     = push_idx;
        wd0     = cp.dinp;
        we1     = 1'b0;
        wi1     = push2_idx;
        wd1     = p_q[WIDTH-1:0];

        if ((state_q != S_IDLE) && (cp.dpsh || cp.dpop)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cp.start) begin
                    if (cnt_q >= CW'(2)) begin
                        a_d     = stk_q[top_idx];
                        b_d     = stk_q[sec_idx];
                        cnt_d   = cnt_q - CW'(2);
                        p_d     = '0;
                        bit_d   = '0;
                        state_d = S_MUL;
                        if (cp.dpsh || cp.dpop) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end else if (cp.dpsh && cp.dpop) begin
                    we0 = 1'b1;
                    if (cnt_q == '0) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        wi0 = top_idx;
                    end
                end else if (cp.dpsh) begin
                    if (cnt_q == CW'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        we0   = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cp.dpop) begin
                    if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_MUL: begin
                p_d   = {mul_sum, p_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                bit_d = bit_q + BW'(1);
                if (bit_q == BW'(WIDTH - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                we0     = 1'b1;
                wd0     = p_q[2*WIDTH-1:WIDTH];
                we1     = 1'b1;
                cnt_d   = cnt_q + CW'(2);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rb) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            bit_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            bit_q   <= bit_d;
            err_q   <= err_d;
        end
    end

    // Stack contents need no reset: the count alone decides what is visible.
    always_ff @(posedge ck) begin
        if (we0) begin
            stk_q[wi0] <= wd0;
        end
        if (we1) begin
            stk_q[wi1] <= wd1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mult_copro.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_copro
//  Purpose  : Scoreboard bench for mult_copro against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_copro;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 4;
    localparam int K_MUL  = 0;
    localparam int K_POP  = 1;
    localparam int K_PEEK = 2;

    typedef struct {
        int          kind;
        int          due;
        logic [31:0] dout;
        logic        err;
    } exp_t;

    logic ck = 1'b0;
    logic rb;
    logic peek = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t        sbq[$];
    exp_t        e_mon;
    logic [31:0] mstk[$];
    logic        merr = 1'b0;

    mult_copro_if #(.WIDTH(WIDTH)) cp ();

    mult_copro #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ck (ck),
        .rb (rb),
        .cp (cp)
    );

    always #5 ck = ~ck;
    always @(posedge ck) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mtop();
        return (mstk.size() == 0) ? 32'd0 : mstk[mstk.size()-1];
    endfunction

    // Monitor: any handshake completion, read-pop or probe consumes one entry.
    always @(negedge ck) begin
        if (!rb && ((cp.start && cp.ready) || (cp.dpop && cp.ready) || peek)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                e_mon = sbq.pop_front();
                chk("dout", {32'd0, cp.dout}, {32'd0, e_mon.dout});
                chk("err", {63'd0, cp.err}, {63'd0, e_mon.err});
                if (e_mon.kind == K_MUL) chk("latency", 64'(cyc), 64'(e_mon.due));
                if (e_mon.kind == K_PEEK) chk("ready", {63'd0, cp.ready}, 64'd1);
            end
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
        cp.dpsh = 1'b0;
        cp.dpop = 1'b0;
        peek    = 1'b0;
    endtask

    task automatic do_reset();
        rb = 1'b1;
        cp.start = 1'b0;
        step();
        rb = 1'b0;
        mstk.delete();
        merr = 1'b0;
    endtask

    task automatic do_push(input logic [31:0] v);
        cp.dpsh = 1'b1;
        cp.dinp = v;
        if (mstk.size() == DEPTH) merr = 1'b1;
        else mstk.push_back(v);
        step();
    endtask

    task automatic do_pop();
        sbq.push_back('{K_POP, 0, mtop(), merr});
        if (mstk.size() == 0) merr = 1'b1;
        else void'(mstk.pop_back());
        cp.dpop = 1'b1;
        step();
    endtask

    task automatic do_repl(input logic [31:0] v);
        sbq.push_back('{K_POP, 0, mtop(), merr});
        if (mstk.size() == 0) mstk.push_back(v);
        else mstk[mstk.size()-1] = v;
        cp.dpsh = 1'b1;
        cp.dpop = 1'b1;
        cp.dinp = v;
        step();
    endtask

    task automatic do_peek();
        sbq.push_back('{K_PEEK, 0, mtop(), merr});
        peek = 1'b1;
        step();
    endtask

    task automatic do_start(input bit inj_req);
        int          c0;
        bit          ok;
        bit          inj;
        bit          got;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        c0  = cyc;
        ok  = (mstk.size() >= 2);
        inj = inj_req && ok;
        if (ok) begin
            a    = mstk.pop_back();
            b    = mstk.pop_back();
            prod = 64'(a) * 64'(b);
            mstk.push_back(prod[63:32]);
            mstk.push_back(prod[31:0]);
            if (inj) merr = 1'b1;
            sbq.push_back('{K_MUL, c0 + WIDTH + 2, mtop(), merr});
        end else begin
            merr = 1'b1;
            sbq.push_back('{K_MUL, c0 + 1, mtop(), merr});
        end
        cp.start = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge ck);
            if (cp.ready) begin
                got = 1'b1;
                break;
            end
            @(posedge ck);
            #1;
            cp.dpsh = inj && (n == 4);
            cp.dinp = $urandom;
        end
        if (!got) begin
            chk("ready_timeout", 64'd0, 64'd1);
            void'(sbq.pop_back());
            do_reset();
        end else begin
            @(posedge ck);
            #1;
            cp.start = 1'b0;
            cp.dpsh  = 1'b0;
        end
    endtask

    task automatic do_mid_reset();
        cp.start = 1'b1;
        repeat (10) begin
            @(posedge ck);
            #1;
        end
        rb = 1'b1;
        cp.start = 1'b0;
        @(posedge ck);
        #1;
        rb = 1'b0;
        mstk.delete();
        merr = 1'b0;
        do_peek();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rb       = 1'b1;
        cp.start = 1'b0;
        cp.dpsh  = 1'b0;
        cp.dpop  = 1'b0;
        cp.dinp  = '0;
        @(posedge ck);
        #1;
        do_reset();
        do_peek();

        do_push(32'd3); do_push(32'd5); do_start(1'b0);
        do_pop(); do_pop(); do_peek();

        do_push(32'hFFFF_FFFF); do_push(32'hFFFF_FFFF); do_start(1'b0);
        do_pop(); do_pop(); do_peek();

        do_push(32'd7); do_push(32'd9); do_repl(32'd4); do_peek();
        do_start(1'b0); do_pop(); do_pop();

        do_reset(); do_pop(); do_peek();
        do_reset();
        for (int i = 1; i <= 5; i++) do_push(32'(i));
        do_peek();
        do_reset(); do_push(32'd2); do_push(32'd3); do_start(1'b1);
        do_pop(); do_pop(); do_peek();

        do_reset(); do_push(32'd6); do_start(1'b0); do_peek(); do_pop(); do_peek();

        do_reset(); do_push(32'd3); do_push(32'd5); do_mid_reset();
        do_push(32'd3); do_push(32'd5); do_start(1'b0); do_pop(); do_pop();

        do_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: do_push(pick());
                3, 4:    do_pop();
                5:       do_repl(pick());
                6, 7:    do_start($urandom_range(0, 3) == 0);
                8:       do_peek();
                default: if ($urandom_range(0, 3) == 0) do_reset(); else do_peek();
            endcase
        end

        repeat (3) step();
        if (sbq.size() != 0) begin
            chk("leftover_expected", 64'(sbq.size()), 64'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
